// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// default reset PC / squash word, PC increment, and the IF/ID payload type.
// Latency: n/a (package). Backpressure: n/a (package).
package ifetch_pkg;

    // Defaults for the instr_fetch parameters.
    localparam logic [31:0] IFETCH_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] IFETCH_NOP_INSTR = 32'h0000_0000;

    // Sequential fetch step, and the mask that forces a redirect word-aligned.
    localparam logic [31:0] IFETCH_PC_INC     = 32'd4;
    localparam logic [31:0] IFETCH_ALIGN_MASK = 32'hFFFF_FFFC;

    // Fetch FSM state encoding.
    typedef logic [1:0] ifetch_state_t;
    localparam ifetch_state_t ST_BOOT  = 2'd0;
    localparam ifetch_state_t ST_RUN   = 2'd1;
    localparam ifetch_state_t ST_HOLD  = 2'd2;
    localparam ifetch_state_t ST_FAULT = 2'd3;

    // Payload carried by the IF/ID pipeline register.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, squash and hold controls.
// Latency: 1 cycle from fetch_dat to if_id_dat.
// Backpressure: holds contents whenever neither load nor squash is asserted.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   load            capture fetch_dat and mark the entry valid
//   squash          replace the instruction with NOP_INSTR and mark it invalid
//   fetch_dat       instruction word + PC+4 from the fetch stage
//   if_id_dat       registered instruction word + PC+4
//   if_id_vld       registered entry holds a real fetched instruction
module if_id_reg
    import ifetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = IFETCH_NOP_INSTR
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   squash,
    input  if_id_t fetch_dat,
    output if_id_t if_id_dat,
    output logic   if_id_vld
);

    // Priority: reset > squash > load > hold. pc4 is left alone on squash;
    // it is meaningless while if_id_vld is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_dat.instr <= NOP_INSTR;
            if_id_dat.pc4   <= '0;
            if_id_vld       <= 1'b0;
        end else if (squash) begin
            if_id_dat.instr <= NOP_INSTR;
            if_id_vld       <= 1'b0;
        end else if (load) begin
            if_id_dat <= fetch_dat;
            if_id_vld <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, fetch FSM and IF/ID register.
// Latency: 1 cycle; the word at imem_addr=A appears on if_id_instr after the next edge.
// Backpressure: stall freezes PC and IF/ID; redirect overrides stall and squashes IF/ID.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   imem_addr           fetch address (the PC register itself)
//   imem_data           instruction word for imem_addr, returned combinationally
//   stall               hold PC and IF/ID
//   redirect            load redirect_target into PC and squash IF/ID
//   redirect_target     next PC on redirect
//   if_id_instr/_pc4    registered instruction and its PC+4
//   if_id_valid         IF/ID holds a real instruction
//   fetch_fault         sticky misaligned-redirect flag
//
// Build option IFETCH_ALIGN_CHECK_EN: when defined, a redirect to a target with
// nonzero low bits raises fetch_fault and parks the stage in FAULT until reset.
// When undefined, the target low bits are cleared and fetch_fault is tied low.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IFETCH_RESET_PC,
    parameter logic [31:0] NOP_INSTR = IFETCH_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        fetch_fault
);

    ifetch_state_t state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   pc_plus4;
    logic          load, squash;
    logic          misaligned;
    if_id_t        fetch_dat;
    if_id_t        if_id_dat;

    // Natural 32-bit wrap: FFFF_FFFC + 4 -> 0000_0000.
    assign pc_plus4 = pc_q + IFETCH_PC_INC;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign misaligned  = |redirect_target[1:0];
    // FAULT is only left through reset, so the state itself is the sticky flag.
    assign fetch_fault = (state_q == ST_FAULT);
`else
    assign misaligned  = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load    = 1'b0;
        squash  = 1'b0;
        case (state_q)
            // BOOT fetches the reset vector unconditionally: nothing is valid
            // downstream yet, so stall/redirect cannot legitimately apply.
            ST_BOOT: begin
                pc_d    = pc_plus4;
                load    = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN, ST_HOLD: begin
                if (redirect) begin
                    squash = 1'b1;
                    if (misaligned) begin
                        // Keep the offending address visible on imem_addr.
                        pc_d    = redirect_target;
                        state_d = ST_FAULT;
                    end else begin
                        pc_d    = redirect_target & IFETCH_ALIGN_MASK;
                        state_d = ST_RUN;
                    end
                end else if (stall) begin
                    state_d = ST_HOLD;
                end else begin
                    pc_d    = pc_plus4;
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign imem_addr = pc_q;

    assign fetch_dat.instr = imem_data;
    assign fetch_dat.pc4   = pc_plus4;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .squash    (squash),
        .fetch_dat (fetch_dat),
        .if_id_dat (if_id_dat),
        .if_id_vld (if_id_valid)
    );

    assign if_id_instr = if_id_dat.instr;
    assign if_id_pc4   = if_id_dat.pc4;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: reference model feeds a scoreboard
// queue each cycle; the DUT state after the edge is popped and compared.
// Memory model: word(A) = A + 0x100.
module tb_instr_fetch;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TB_NOP      = 32'h0000_0013;
    localparam logic [31:0] WORD_OFS    = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        fetch_fault;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign imem_data = imem_addr + WORD_OFS;

    instr_fetch #(
        .RESET_PC  (TB_RESET_PC),
        .NOP_INSTR (TB_NOP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .if_id_instr     (if_id_instr),
        .if_id_pc4       (if_id_pc4),
        .if_id_valid     (if_id_valid),
        .fetch_fault     (fetch_fault)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        fault;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state.
    logic        m_boot  = 1'b1;
    logic        m_fault = 1'b0;
    logic [31:0] m_pc    = TB_RESET_PC;
    logic [31:0] m_instr = TB_NOP;
    logic [31:0] m_pc4   = 32'h0;
    logic        m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_update(input logic rst, input logic stl, input logic rdr,
                                input logic [31:0] tgt);
        if (rst) begin
            m_boot = 1'b1; m_fault = 1'b0; m_pc = TB_RESET_PC;
            m_instr = TB_NOP; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (m_boot) begin
            m_instr = m_pc + WORD_OFS; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            m_pc = m_pc + 32'd4; m_boot = 1'b0;
        end else if (m_fault) begin
            // frozen until reset
        end else if (rdr) begin
            m_instr = TB_NOP; m_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
            if (tgt[1:0] != 2'b00) begin
                m_fault = 1'b1; m_pc = tgt;
            end else begin
                m_pc = tgt;
            end
`else
            m_pc = {tgt[31:2], 2'b00};
`endif
        end else if (!stl) begin
            m_instr = m_pc + WORD_OFS; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end
    endtask

    // One clock: drive inputs, push the model's prediction, compare after the edge.
    task automatic step(input logic rst, input logic stl, input logic rdr,
                        input logic [31:0] tgt);
        exp_t e;
        exp_t o;
        @(negedge clk);
        reset = rst; stall = stl; redirect = rdr; redirect_target = tgt;
        model_update(rst, stl, rdr, tgt);
        e.addr = m_pc; e.instr = m_instr; e.pc4 = m_pc4;
        e.valid = m_valid; e.fault = m_fault;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            o = sb_q.pop_front();
            check("sb_addr",  imem_addr,          o.addr);
            check("sb_instr", if_id_instr,        o.instr);
            check("sb_pc4",   if_id_pc4,          o.pc4);
            check("sb_valid", {31'b0, if_id_valid}, {31'b0, o.valid});
            check("sb_fault", {31'b0, fetch_fault}, {31'b0, o.fault});
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;

        // Reset for two cycles, with stall/redirect asserted to show reset wins.
        step(1'b1, 1'b1, 1'b1, 32'h40);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("boot_addr",  imem_addr, 32'h0);
        check("boot_valid", {31'b0, if_id_valid}, 32'h0);
        check("rst_instr",  if_id_instr, TB_NOP);

        // BOOT edge fetches 0x0, then free run.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("run_addr4", imem_addr, 32'h4);
        check("boot_word", if_id_instr, 32'h100);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("run_addr8", imem_addr, 32'h8);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("fetch8_instr", if_id_instr, 32'h108);
        check("fetch8_pc4",   if_id_pc4,   32'hC);
        check("fetch8_valid", {31'b0, if_id_valid}, 32'h1);

        // Stall three cycles at PC=0xC, then release.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        check("stall_addr",  imem_addr,   32'hC);
        check("stall_instr", if_id_instr, 32'h108);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("unstall_instr", if_id_instr, 32'h10C);

        // Redirect beats stall.
        run(2);
        step(1'b0, 1'b1, 1'b1, 32'h10);
        check("redir_addr",  imem_addr,   32'h10);
        check("redir_instr", if_id_instr, TB_NOP);
        check("redir_valid", {31'b0, if_id_valid}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("redir_next", if_id_instr, 32'h110);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc4",  if_id_pc4, 32'h0);

        // Random mix of stalls and redirects.
        for (int i = 0; i < 60; i++) begin
            logic        s;
            logic        r;
            logic [31:0] t;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 7) == 0);
            t = $urandom;
`ifdef IFETCH_ALIGN_CHECK_EN
            t[1:0] = 2'b00;
`endif
            step(1'b0, s, r, t);
        end

        // Misaligned redirect target.
        step(1'b0, 1'b0, 1'b1, 32'h22);
`ifdef IFETCH_ALIGN_CHECK_EN
        check("mis_fault", {31'b0, fetch_fault}, 32'h1);
        check("mis_addr",  imem_addr, 32'h22);
        step(1'b0, 1'b0, 1'b1, 32'h80);
        run(2);
        check("fault_frozen", imem_addr, 32'h22);
        check("fault_valid",  {31'b0, if_id_valid}, 32'h0);
`else
        check("mis_fault", {31'b0, fetch_fault}, 32'h0);
        check("mis_addr",  imem_addr, 32'h20);
        run(2);
        check("mis_run", if_id_instr, 32'h124);
`endif

        // Reset mid-stream discards everything, then boots again.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("mid_rst_valid", {31'b0, if_id_valid}, 32'h0);
        check("mid_rst_fault", {31'b0, fetch_fault}, 32'h0);
        check("mid_rst_addr",  imem_addr, TB_RESET_PC);
        run(3);
        check("reboot_instr", if_id_instr, 32'h108);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC loaded on reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h00000000, meaning the word loaded into IF/ID on squash.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port imem_addr  output  32  fetch address to the instruction memory; equals current PC.
REQ-006 The block SHALL have port imem_data  input  32  instruction word returned combinationally for imem_addr.
REQ-007 The block SHALL have port stall  input  1  hold PC and IF/ID (hazard from decode).
REQ-008 The block SHALL have port redirect  input  1  taken branch or jump resolved downstream.
REQ-009 The block SHALL have port redirect_target  input  32  next PC when redirect=1.
REQ-010 The block SHALL have port if_id_instr  output  32  registered instruction to decode.
REQ-011 The block SHALL have port if_id_pc4  output  32  registered PC+4 of if_id_instr.
REQ-012 The block SHALL have port if_id_valid  output  1  if_id_instr is a real fetched instruction.
REQ-013 The block SHALL have port fetch_fault  output  1  sticky misaligned-redirect flag (macro-dependent).

Function
REQ-014 The FSM SHALL have states BOOT, RUN, HOLD, FAULT; BOOT is entered on reset.
REQ-015 BOOT SHALL last exactly one cycle, fetch from RESET_PC, keep if_id_valid=0, then go to RUN.
REQ-016 In RUN with stall=0 and redirect=0: PC <= PC+4; if_id_instr <= imem_data; if_id_pc4 <= PC+4; if_id_valid <= 1.
REQ-017 PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000); no carry out.
REQ-018 stall=1 with redirect=0 SHALL enter/remain in HOLD: PC and all IF/ID outputs unchanged; stall=0 returns to RUN.
REQ-019 redirect=1 SHALL load PC <= redirect_target and squash IF/ID (if_id_instr <= NOP_INSTR, if_id_valid <= 0) in the same edge.
REQ-020 redirect SHALL take priority over stall when both are 1; the FSM goes to RUN.
REQ-021 Fetch latency SHALL be one cycle: the word at address A appears on if_id_instr the edge after imem_addr=A is sampled.
REQ-022 imem_addr SHALL be driven directly from the PC register (no combinational path from stall/redirect).

Reset
REQ-023 reset=1 SHALL, on the next rising edge, set PC=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0, fetch_fault=0, state=BOOT.
REQ-024 reset SHALL override stall, redirect and FAULT; reset mid-stream discards the in-flight instruction.

Configuration
REQ-025 With IFETCH_ALIGN_CHECK_EN defined, redirect with redirect_target[1:0]!=0 SHALL set fetch_fault=1, enter FAULT, freeze PC and hold if_id_valid=0 until reset.
REQ-026 Without IFETCH_ALIGN_CHECK_EN, redirect_target[1:0] SHALL be forced to 2'b00, fetch_fault tied 0, FAULT state unreachable.

Structure
REQ-027 The shared package ifetch_pkg SHALL hold the FSM state enum, the default RESET_PC and NOP_INSTR constants, and the PC increment constant (4).
REQ-028 One sub-module if_id_reg (IF/ID register with load, squash and hold controls) is natural and SHALL be used.

Verification
REQ-029 reset for 2 cycles, release -> imem_addr=0x0, if_id_valid=0 for the BOOT cycle, then 0x4, 0x8 on successive edges.
REQ-030 free run with memory word(A)=A+0x100 -> after edge fetching 0x8: if_id_instr=0x108, if_id_pc4=0xC, valid=1.
REQ-031 stall=1 for 3 cycles at PC=0xC -> imem_addr stays 0xC, IF/ID frozen; release -> next if_id_instr=word(0xC).
REQ-032 redirect=1, target=0x10, stall=1 same cycle -> PC=0x10, if_id_valid=0, if_id_instr=NOP_INSTR; next edge if_id_instr=word(0x10).
REQ-033 PC=0xFFFFFFFC free run -> next imem_addr=0x00000000.
REQ-034 redirect target=0x22: with IFETCH_ALIGN_CHECK_EN -> fetch_fault=1, PC frozen at 0x22 until reset; without -> PC=0x20, fault=0.
